// File: rtl/dec_pkg.sv
// Shared constants and width helpers for the pipelined one-hot decoder family.
package dec_pkg;

   localparam int DEC_MAX_N = 11;
   localparam int DEC_MIN_N = 2;

   function automatic int lo_w(input int n);
      return (n + 1) / 2;
   endfunction

   function automatic int hi_w(input int n);
      return n / 2;
   endfunction

endpackage

// File: rtl/predec_n.sv
// Combinational W -> 2^W one-hot predecoder, used for each address half ahead of S1.
module predec_n #(
   parameter int W = 4
) (
   input  logic [W-1:0]      i_addr,
   output logic [(1<<W)-1:0] o_onehot
);

   always_comb begin
      o_onehot         = '0;
      o_onehot[i_addr] = 1'b1;
   end

endmodule

// File: rtl/decoder_pipe.sv
// Two-stage valid/ready N -> 2^N one-hot decoder: predecode halves in S1, AND matrix in S2.
// Optional parity checking is enabled with `define DECODER_PARITY_EN.
module decoder_pipe
   import dec_pkg::*;
#(
   parameter int N = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N-1:0]    a,
   input  logic            a_par,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [2**N-1:0] z,
   output logic            par_err
);

   localparam int LO_W = lo_w(N);
   localparam int HI_W = hi_w(N);
   localparam int LO_D = 1 << LO_W;
   localparam int HI_D = 1 << HI_W;
   localparam int Z_W  = 1 << N;

   if (N < DEC_MIN_N || N > DEC_MAX_N) begin : g_bad_n
      $error("decoder_pipe: N=%0d outside legal range %0d..%0d", N, DEC_MIN_N, DEC_MAX_N);
   end

   logic [LO_D-1:0] w_xlo;
   logic [HI_D-1:0] w_yhi;
   logic [LO_D-1:0] r_xlo_p1;
   logic [HI_D-1:0] r_yhi_p1;
   logic            r_vld_p1;
   logic [Z_W-1:0]  w_z_p1;
   logic [Z_W-1:0]  r_z_p2;
   logic            r_vld_p2;
   logic            w_s1_adv;
   logic            w_s2_adv;

   predec_n #(.W(LO_W)) u_predec_lo (
      .i_addr   (a[LO_W-1:0]),
      .o_onehot (w_xlo)
   );

   predec_n #(.W(HI_W)) u_predec_hi (
      .i_addr   (a[N-1:LO_W]),
      .o_onehot (w_yhi)
   );

   // S2 can load whenever its slot is empty or being drained; in_ready looks through it.
   assign w_s2_adv = r_vld_p1 & (~r_vld_p2 | out_ready);
   assign in_ready = ~r_vld_p1 | w_s2_adv;
   assign w_s1_adv = in_valid & in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_p1 <= 1'b0;
         r_vld_p2 <= 1'b0;
      end else begin
         r_vld_p1 <= w_s1_adv | (r_vld_p1 & ~w_s2_adv);
         r_vld_p2 <= w_s2_adv | (r_vld_p2 & ~out_ready);
      end
   end

   // ---- S1: registered predecode of low / high address halves ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_xlo_p1 <= '0;
         r_yhi_p1 <= '0;
      end else if (w_s1_adv) begin
         r_xlo_p1 <= w_xlo;
         r_yhi_p1 <= w_yhi;
      end
   end

   for (genvar gi = 0; gi < HI_D; gi++) begin : g_row
      for (genvar gj = 0; gj < LO_D; gj++) begin : g_col
         assign w_z_p1[gi*LO_D + gj] = r_xlo_p1[gj] & r_yhi_p1[gi];
      end
   end

   // ---- S2: AND-matrix output register ----
`ifdef DECODER_PARITY_EN
   logic r_perr_p1;
   logic r_perr_p2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perr_p1 <= 1'b0;
      end else if (w_s1_adv) begin
         r_perr_p1 <= ^{a, a_par};
      end
   end

   // A word with bad parity is emitted as all-zero so no row/column is selected.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perr_p2 <= 1'b0;
         r_z_p2    <= '0;
      end else if (w_s2_adv) begin
         r_perr_p2 <= r_perr_p1;
         r_z_p2    <= r_perr_p1 ? '0 : w_z_p1;
      end
   end

   assign par_err = r_perr_p2;
`else
   logic w_unused_par;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_z_p2 <= '0;
      end else if (w_s2_adv) begin
         r_z_p2 <= w_z_p1;
      end
   end

   assign w_unused_par = a_par;
   assign par_err      = 1'b0;
`endif

   assign z         = r_z_p2;
   assign out_valid = r_vld_p2;

endmodule

// File: tb/tb_decoder_pipe.sv
// Scoreboard bench for decoder_pipe: N=8 main instance plus N=2/5/11 exhaustive sweep instances.
module tb_decoder_pipe;

   localparam int N  = 8;
   localparam int ZW = 1 << N;

   typedef struct {
      int addr;
      bit perr;
      int t_acc;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  a;
   logic          a_par;
   logic          out_valid;
   logic          out_ready;
   logic [ZW-1:0] z;
   logic          par_err;

   logic [2:0]    sw_iv;
   logic [2:0]    sw_ir;
   logic [2:0]    sw_ov;
   logic [2:0]    sw_pe;
   logic [2:0]    sw_par;
   logic [1:0]    sw_a2;
   logic [4:0]    sw_a5;
   logic [10:0]   sw_a11;
   logic [3:0]    z2;
   logic [31:0]   z5;
   logic [2047:0] z11;

   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;
   exp_t q[$];
   int   sq[3][$];
   bit   lat_exact = 1'b0;
   bit   hold_v    = 1'b0;
   logic [ZW-1:0] hold_z;
   logic          hold_pe;
   bit   rnd_done;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   decoder_pipe #(.N(N)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .a_par(a_par),
      .out_valid(out_valid), .out_ready(out_ready), .z(z), .par_err(par_err)
   );

   assign sw_par[0] = ^sw_a2;
   assign sw_par[1] = ^sw_a5;
   assign sw_par[2] = ^sw_a11;

   decoder_pipe #(.N(2)) u_sw2 (
      .clk(clk), .rst_n(rst_n), .in_valid(sw_iv[0]), .in_ready(sw_ir[0]), .a(sw_a2), .a_par(sw_par[0]),
      .out_valid(sw_ov[0]), .out_ready(1'b1), .z(z2), .par_err(sw_pe[0])
   );
   decoder_pipe #(.N(5)) u_sw5 (
      .clk(clk), .rst_n(rst_n), .in_valid(sw_iv[1]), .in_ready(sw_ir[1]), .a(sw_a5), .a_par(sw_par[1]),
      .out_valid(sw_ov[1]), .out_ready(1'b1), .z(z5), .par_err(sw_pe[1])
   );
   decoder_pipe #(.N(11)) u_sw11 (
      .clk(clk), .rst_n(rst_n), .in_valid(sw_iv[2]), .in_ready(sw_ir[2]), .a(sw_a11), .a_par(sw_par[2]),
      .out_valid(sw_ov[2]), .out_ready(1'b1), .z(z11), .par_err(sw_pe[2])
   );

   // Reference model: the addressed bit alone, or nothing when the word carries bad parity.
   function automatic bit good_par(input int v);
      return bit'($countones(v) % 2);
   endfunction

   function automatic bit model_perr(input int v, input bit ap);
`ifdef DECODER_PARITY_EN
      return ap != good_par(v);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [ZW-1:0] exp_z(input int v, input bit pe);
      logic [ZW-1:0] r;
      r = '0;
      if (!pe) r[v] = 1'b1;
      return r;
   endfunction

   task automatic chk(input string nm, input bit ok, input string detail);
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL %s: %s", nm, detail);
      end
   endtask

   // Monitor: record accepted inputs, compare each emitted word, and police output stability.
   always @(negedge clk) begin
      exp_t e;
      int   sa;
      int   ea;
      bit   b;
      int   c;
      if (!rst_n) begin
         hold_v = 1'b0;
      end else begin
         if (hold_v)
            chk("hold", out_valid && z == hold_z && par_err == hold_pe,
                $sformatf("got ov=%b z=%h pe=%b want ov=1 z=%h pe=%b", out_valid, z, par_err, hold_z, hold_pe));
         if (out_valid) begin
            chk("spurious", q.size() != 0, $sformatf("out_valid=1 with %0d words expected", q.size()));
            if (q.size() != 0 && out_ready) begin
               e = q.pop_front();
               chk("word", z == exp_z(e.addr, e.perr) && par_err == e.perr,
                   $sformatf("a=%0d got z=%h pe=%b want z=%h pe=%b", e.addr, z, par_err, exp_z(e.addr, e.perr), e.perr));
               if (lat_exact)
                  chk("latency", cyc - e.t_acc == 2, $sformatf("a=%0d got %0d cycles want 2", e.addr, cyc - e.t_acc));
            end
         end
         hold_v  = out_valid && !out_ready;
         hold_z  = z;
         hold_pe = par_err;
         if (in_valid && in_ready) q.push_back('{int'(a), model_perr(int'(a), a_par), cyc});

         for (int k = 0; k < 3; k++) begin
            if (sw_ov[k]) begin
               chk("sweep_spurious", sq[k].size() != 0, $sformatf("sweep %0d out_valid=1 with empty queue", k));
               if (sq[k].size() != 0) begin
                  ea = sq[k].pop_front();
                  case (k)
                     0:       begin b = z2[ea];  c = $countones(z2);  end
                     1:       begin b = z5[ea];  c = $countones(z5);  end
                     default: begin b = z11[ea]; c = $countones(z11); end
                  endcase
                  chk("sweep", b && c == 1 && !sw_pe[k],
                      $sformatf("inst %0d a=%0d got bit=%b popcount=%0d pe=%b want bit=1 popcount=1 pe=0", k, ea, b, c, sw_pe[k]));
               end
            end
            if (sw_iv[k] && sw_ir[k]) begin
               case (k)
                  0:       sa = int'(sw_a2);
                  1:       sa = int'(sw_a5);
                  default: sa = int'(sw_a11);
               endcase
               sq[k].push_back(sa);
            end
         end
      end
   end

   task automatic send(input int av, input bit ap);
      bit got;
      got      = 1'b0;
      in_valid = 1'b1;
      a        = N'(av);
      a_par    = ap;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         got = in_ready;
         @(posedge clk);
         #1;
         if (got) break;
      end
      chk("accept", got, $sformatf("a=%0d accepted=%b want 1 within 200 cycles", av, got));
   endtask

   task automatic sw_send(input int k, input int av);
      bit got;
      got = 1'b0;
      sw_iv[k] = 1'b1;
      case (k)
         0:       sw_a2  = 2'(av);
         1:       sw_a5  = 5'(av);
         default: sw_a11 = 11'(av);
      endcase
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         got = sw_ir[k];
         @(posedge clk);
         #1;
         if (got) break;
      end
      chk("sw_accept", got, $sformatf("inst %0d a=%0d accepted=%b want 1", k, av, got));
   endtask

   task automatic drain(input string nm);
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         if (q.size() == 0) break;
      end
      chk(nm, q.size() == 0, $sformatf("%0d words outstanding want 0", q.size()));
      @(posedge clk);
      #1;
   endtask

   initial begin
      int nacc;
      bit acc;
      int av;
      rst_n = 1'b0; in_valid = 1'b0; a = '0; a_par = 1'b0; out_ready = 1'b0;
      sw_iv = '0; sw_a2 = '0; sw_a5 = '0; sw_a11 = '0;
      @(posedge clk);
      #1;
      chk("rst_state", out_valid == 1'b0 && z == '0 && par_err == 1'b0,
          $sformatf("got ov=%b z=%h pe=%b want 0,0,0", out_valid, z, par_err));
      chk("rst_in_ready", in_ready == 1'b1, $sformatf("got %b want 1", in_ready));
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Streaming with exact 2-cycle latency, including both address extremes.
      out_ready = 1'b1;
      lat_exact = 1'b1;
      send(0, good_par(0));
      send(1, good_par(1));
      send(255, good_par(255));
      send(170, good_par(170));
      in_valid = 1'b0;
      drain("stream_drain");
      lat_exact = 1'b0;

      // Backpressure: two accepts fill the pipe, then the input stalls.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      av        = 5;
      a         = N'(av);
      a_par     = good_par(av);
      nacc      = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         acc = in_ready;
         if (acc) nacc++;
         @(posedge clk);
         #1;
         if (acc) begin
            av++;
            a     = N'(av);
            a_par = good_par(av);
         end
      end
      @(negedge clk);
      chk("bp_accepts", nacc == 2, $sformatf("got %0d accepts want 2", nacc));
      chk("bp_in_ready", in_ready == 1'b0, $sformatf("got %b want 0", in_ready));
      chk("bp_head", out_valid && z == exp_z(5, 1'b0), $sformatf("got ov=%b z=%h want ov=1 z=%h", out_valid, z, exp_z(5, 1'b0)));
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(7, good_par(7));
      in_valid = 1'b0;
      drain("bp_drain");

      // Parity: a=3 with odd total parity, then with correct parity.
      send(3, 1'b1);
      send(3, 1'b0);
      in_valid = 1'b0;
      drain("par_drain");

      // Reset with two words in flight: both must vanish.
      out_ready = 1'b0;
      send(9, good_par(9));
      send(10, good_par(10));
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid", out_valid == 1'b0 && z == '0 && par_err == 1'b0,
          $sformatf("got ov=%b z=%h pe=%b want 0,0,0", out_valid, z, par_err));
      q.delete();
      #10 rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("post_rst_idle", out_valid == 1'b0, $sformatf("cycle %0d got ov=%b want 0", i, out_valid));
      end
      @(posedge clk);
      #1;

      // Random traffic with random backpressure and occasional bad parity.
      rnd_done = 1'b0;
      fork
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
         begin
            for (int i = 0; i < 10000; i++) begin
               if ($urandom_range(0, 3) == 0) begin
                  in_valid = 1'b0;
                  @(posedge clk);
                  #1;
               end
               av = int'($urandom_range(0, ZW - 1));
               send(av, good_par(av) ^ ($urandom_range(0, 7) == 0));
            end
            in_valid = 1'b0;
            rnd_done = 1'b1;
         end
      join
      out_ready = 1'b1;
      drain("rand_drain");

      // Exhaustive sweeps on the small and maximum widths.
      for (int k = 0; k < 3; k++) begin
         int nb;
         nb = (k == 0) ? 2 : (k == 1) ? 5 : 11;
         for (int v = 0; v < (1 << nb); v++) sw_send(k, v);
         sw_iv[k] = 1'b0;
         for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (sq[k].size() == 0) break;
         end
         chk("sweep_drain", sq[k].size() == 0, $sformatf("inst %0d %0d words outstanding want 0", k, sq[k].size()));
         @(posedge clk);
         #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
